// File: rtl/tdc_pulse_gen_if.sv
// Request/status bundle between a pulse-train requester and tdc_pulse_gen.
// TDC_PULSE_GEN_RUNTIME_TIMING_EN adds per-sequence high_len/low_len.
interface tdc_pulse_gen_if #(
    parameter int CW = 8
`ifdef TDC_PULSE_GEN_RUNTIME_TIMING_EN
    , parameter int TW = 8
`endif
);
    logic          load;
    logic [CW-1:0] count_in;
`ifdef TDC_PULSE_GEN_RUNTIME_TIMING_EN
    logic [TW-1:0] high_len;
    logic [TW-1:0] low_len;
`endif
    logic          start_out;
    logic          pulse_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] sent_count;

`ifdef TDC_PULSE_GEN_RUNTIME_TIMING_EN
    modport master (output load, count_in, high_len, low_len,
                    input  start_out, pulse_out, busy, done, sent_count);
    modport slave  (input  load, count_in, high_len, low_len,
                    output start_out, pulse_out, busy, done, sent_count);
`else
    modport master (output load, count_in,
                    input  start_out, pulse_out, busy, done, sent_count);
    modport slave  (input  load, count_in,
                    output start_out, pulse_out, busy, done, sent_count);
`endif
endinterface

// File: rtl/tdc_pulse_gen.sv
// Start strobe + N-pulse train source for TDC calibration/loopback.
// TDC_PULSE_GEN_RUNTIME_TIMING_EN: high/low widths captured from the bus with load.
module tdc_pulse_gen #(
    parameter int CW           = 8,
    parameter int TW           = 8,
    parameter int START_CYCLES = 5,
    parameter int GAP_CYCLES   = 5,
    parameter int HIGH_CYCLES  = 5,
    parameter int LOW_CYCLES   = 5
) (
    input  logic             clk,
    input  logic             rst,
    tdc_pulse_gen_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, START, GAP, HIGH, LOW, DONE} state_t;

    // zero-length phases are stretched to one cycle
    localparam logic [TW-1:0] S_LEN = (START_CYCLES < 1) ? TW'(1) : TW'(START_CYCLES);
    localparam logic [TW-1:0] G_LEN = (GAP_CYCLES   < 1) ? TW'(1) : TW'(GAP_CYCLES);
    localparam logic [TW-1:0] H_DEF = (HIGH_CYCLES  < 1) ? TW'(1) : TW'(HIGH_CYCLES);
    localparam logic [TW-1:0] L_DEF = (LOW_CYCLES   < 1) ? TW'(1) : TW'(LOW_CYCLES);

    state_t        state, state_nxt;
    logic [TW-1:0] tmr;
    logic [TW-1:0] cur_len;
    logic [TW-1:0] hlen, llen;
    logic [CW-1:0] remaining;
    logic [CW-1:0] sent_q;
    logic          start_q, pulse_q, busy_q, done_q;
    logic          accept, phase_end;

    assign accept    = (state == IDLE) && bus.load;
    assign phase_end = (tmr == cur_len - 1'b1);

`ifdef TDC_PULSE_GEN_RUNTIME_TIMING_EN
    logic [TW-1:0] hlen_q, llen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hlen_q <= H_DEF;
            llen_q <= L_DEF;
        end else if (accept) begin
            hlen_q <= (bus.high_len == '0) ? TW'(1) : bus.high_len;
            llen_q <= (bus.low_len  == '0) ? TW'(1) : bus.low_len;
        end
    end

    assign hlen = hlen_q;
    assign llen = llen_q;
`else
    assign hlen = H_DEF;
    assign llen = L_DEF;
`endif

    always_comb begin
        cur_len = TW'(1);
        case (state)
            START:   cur_len = S_LEN;
            GAP:     cur_len = G_LEN;
            HIGH:    cur_len = hlen;
            LOW:     cur_len = llen;
            default: cur_len = TW'(1);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept)    state_nxt = START;
            START: if (phase_end) state_nxt = GAP;
            GAP:   if (phase_end) state_nxt = (remaining == '0) ? DONE : HIGH;
            HIGH:  if (phase_end) state_nxt = LOW;
            // remaining is decremented on this same edge, so test for 1
            LOW:   if (phase_end) state_nxt = (remaining == CW'(1)) ? DONE : HIGH;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs decoded from next state so they align with the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr       <= '0;
            remaining <= '0;
            sent_q    <= '0;
            start_q   <= 1'b0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tmr <= (state_nxt != state) ? '0 : tmr + 1'b1;
            if (accept) begin
                remaining <= bus.count_in;
                sent_q    <= '0;
            end else if (state == LOW && phase_end) begin
                remaining <= remaining - 1'b1;
                sent_q    <= sent_q + 1'b1;
            end
            start_q <= (state_nxt == START);
            pulse_q <= (state_nxt == HIGH);
            busy_q  <= (state_nxt == START) || (state_nxt == GAP) ||
                       (state_nxt == HIGH)  || (state_nxt == LOW);
            done_q  <= (state_nxt == DONE);
        end
    end

    assign bus.start_out  = start_q;
    assign bus.pulse_out  = pulse_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sent_count = sent_q;
endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Scoreboard bench for tdc_pulse_gen: expected sequences queued at load, checked as outputs appear.
module tb_tdc_pulse_gen;
    localparam int S = 5;
    localparam int G = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdc_pulse_gen_if bus();
    tdc_pulse_gen dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { int n; int h; int l; int e0; } exp_t;
    exp_t q[$];

    int cyc = 0;
    int total = 0, bad = 0;
    int ndone = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // monitor + loopback counter model
    logic prev_s = 0, prev_p = 0, prev_d = 0;
    int   slen = 0, lb = 0, last_rise = 0, rel = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_s = 0; prev_p = 0; prev_d = 0; slen = 0; lb = 0;
        end else begin
            rel = (q.size() != 0) ? cyc - q[0].e0 : 0;
            if (bus.start_out && !prev_s) begin
                if (q.size() == 0) chk("start_unexp", 1, 0);
                else begin
                    chk("start_rel", rel, 1);
                    chk("busy_start", bus.busy, 1);
                end
                lb = 0; slen = 0;
            end
            if (bus.start_out) slen++;
            if (!bus.start_out && prev_s) chk("start_len", slen, S);
            if (bus.pulse_out && !prev_p && q.size() != 0) begin
                lb++;
                if (lb == 1) chk("first_pulse", rel, S + G + 1);
                else         chk("period", rel - last_rise, q[0].h + q[0].l);
                last_rise = rel;
            end
            if (!bus.pulse_out && prev_p && q.size() != 0)
                chk("high_w", rel - last_rise, q[0].h);
            if (bus.done) begin
                if (prev_d) chk("done_1cyc", 1, 0);
                if (q.size() == 0) chk("done_unexp", 1, 0);
                else begin
                    chk("done_rel", rel, S + G + q[0].n * (q[0].h + q[0].l) + 1);
                    chk("sent_count", bus.sent_count, q[0].n);
                    chk("busy_at_done", bus.busy, 0);
                    chk("loopback", lb, q[0].n);
                    void'(q.pop_front());
                end
                ndone++;
            end
            prev_s = bus.start_out; prev_p = bus.pulse_out; prev_d = bus.done;
        end
    end

    task automatic kick(input int n, input int h, input int l, input bit hold);
        exp_t e;
        @(negedge clk);
        bus.load = 1'b1;
        bus.count_in = 8'(n);
`ifdef TDC_PULSE_GEN_RUNTIME_TIMING_EN
        bus.high_len = 8'(h);
        bus.low_len  = 8'(l);
`endif
        @(posedge clk);
        #1;
        e.n = n; e.h = h; e.l = l; e.e0 = cyc - 1;
        q.push_back(e);
        if (!hold) begin
            @(negedge clk);
            bus.load = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start_n = ndone;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (ndone != start_n) break;
        end
        chk(tag, ndone != start_n, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, bus.start_out, 0);
        chk({tag, "_pulse"}, bus.pulse_out, 0);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_done"},  bus.done, 0);
        chk({tag, "_sent"},  bus.sent_count, 0);
    endtask

    initial begin
        int saved;
        bus.load = 1'b0;
        bus.count_in = '0;
`ifdef TDC_PULSE_GEN_RUNTIME_TIMING_EN
        bus.high_len = 8'd5;
        bus.low_len  = 8'd5;
`endif
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        kick(3, 5, 5, 0);   wait_done("to_n3", 200);
        kick(0, 5, 5, 0);   wait_done("to_n0", 200);
        chk("sent_hold", bus.sent_count, 0);
        kick(255, 5, 5, 0); wait_done("to_n255", 3000);
        kick(1, 5, 5, 0);   wait_done("to_n1", 200);

        // load held high (count_in=7) throughout a 2-pulse sequence
        kick(2, 5, 5, 1);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            bus.count_in = 8'd7;
        end
        bus.load = 1'b0;
        wait_done("to_hold", 200);
        repeat (20) @(negedge clk);
        chk("no_restart", bus.busy, 0);

        // async reset mid-sequence
        kick(4, 5, 5, 0);
        repeat (16) @(negedge clk);
        saved = ndone;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("no_done_after_rst", ndone, saved);
        kick(1, 5, 5, 0);   wait_done("to_after_rst", 200);

`ifdef TDC_PULSE_GEN_RUNTIME_TIMING_EN
        kick(4, 2, 3, 0);   wait_done("to_rt", 200);
`endif
        repeat (5) @(negedge clk);
        chk("q_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
